// File: rtl/game_pkg.sv
// Shared definitions for the quidditch match sequencer.
// Holds the game state encoding, winner codes, the player recentre
// position and the default frame counts for the serve and goal phases.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_TEAM1 = 2'b01;
  localparam logic [1:0] WIN_TEAM2 = 2'b10;

  // Vertical position the player controllers return to on pos_reset.
  localparam int PLAYER_CENTRE = 240;

  localparam int DEFAULT_WIN_SCORE    = 7;
  localparam int DEFAULT_SERVE_FRAMES = 60;
  localparam int DEFAULT_GOAL_FRAMES  = 120;

endpackage

// File: rtl/frame_timer.sv
// Frame down-counter shared by the SERVE and GOAL phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load count with load_val (has priority over tick)
//   load_val   : value loaded on load
//   tick       : count one frame
//   done       : high when tick arrives while count == 1
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = tick && (count_reg == W'(1));

endmodule

// File: rtl/match_controller.sv
// Top-level game sequencer for the quidditch datapath.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   frame_tick     : one-cycle pulse per video frame
//   start_button   : raw active-low start button (asynchronous)
//   goal_team1/2   : one-cycle goal pulses from the ball controller
//   play_en        : movement enable for players and ball
//   pos_reset      : one-cycle recentre pulse on every serve entry
//   serve_dir      : 0 = serve toward team1, 1 = toward team2
//   team1/2_score  : current scores
//   winner         : 00 none, 01 team1, 10 team2
//   game_state     : state encoding for display/debug
module match_controller
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int SERVE_FRAMES = DEFAULT_SERVE_FRAMES,
  parameter int GOAL_FRAMES  = DEFAULT_GOAL_FRAMES,
  parameter int TIMER_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_button,
  input  logic       goal_team1,
  input  logic       goal_team2,
  output logic       play_en,
  output logic       pos_reset,
  output logic       serve_dir,
  output logic [3:0] team1_score,
  output logic [3:0] team2_score,
  output logic [1:0] winner,
  output logic [2:0] game_state
);

  localparam logic [3:0]         WIN_VAL   = 4'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_VAL = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] GOAL_VAL  = TIMER_W'(GOAL_FRAMES);

  // Start button synchroniser and falling-edge press detector.
  logic sync1_reg, sync2_reg, sync3_reg;
  logic press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      sync3_reg <= 1'b1;
    end else begin
      sync1_reg <= start_button;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign press = sync3_reg && !sync2_reg;

  // Registered state and outputs.
  game_state_t state_reg, state_next;
  logic        play_en_reg, play_en_next;
  logic        pos_reset_reg, pos_reset_next;
  logic        serve_dir_reg, serve_dir_next;
  logic [3:0]  score1_reg, score1_next;
  logic [3:0]  score2_reg, score2_next;
  logic [1:0]  winner_reg, winner_next;
  // High during the first cycle of SERVE or GOAL, where a frame_tick is not counted.
  logic        first_reg, first_next;

  logic                timer_load;
  logic [TIMER_W-1:0]  timer_load_val;
  logic                timer_tick;
  logic                timer_done;

  assign timer_tick = frame_tick && !first_reg &&
                      ((state_reg == ST_SERVE) || (state_reg == ST_GOAL));

  frame_timer #(
    .W(TIMER_W)
  ) u_frame_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .tick     (timer_tick),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      play_en_reg   <= 1'b0;
      pos_reset_reg <= 1'b0;
      serve_dir_reg <= 1'b0;
      score1_reg    <= 4'd0;
      score2_reg    <= 4'd0;
      winner_reg    <= WIN_NONE;
      first_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      play_en_reg   <= play_en_next;
      pos_reset_reg <= pos_reset_next;
      serve_dir_reg <= serve_dir_next;
      score1_reg    <= score1_next;
      score2_reg    <= score2_next;
      winner_reg    <= winner_next;
      first_reg     <= first_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    serve_dir_next = serve_dir_reg;
    score1_next    = score1_reg;
    score2_next    = score2_reg;
    winner_next    = winner_reg;
    timer_load     = 1'b0;
    timer_load_val = SERVE_VAL;

    unique case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (press) begin
          state_next     = ST_SERVE;
          timer_load     = 1'b1;
          timer_load_val = SERVE_VAL;
          score1_next    = 4'd0;
          score2_next    = 4'd0;
          winner_next    = WIN_NONE;
          serve_dir_next = 1'b0;
        end
      end

      ST_SERVE: begin
        if (timer_done) begin
          state_next = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // Simultaneous goals cancel out and are ignored.
        if (goal_team1 && !goal_team2) begin
          state_next     = ST_GOAL;
          score1_next    = score1_reg + 4'd1;
          serve_dir_next = 1'b0;
          timer_load     = 1'b1;
          timer_load_val = GOAL_VAL;
        end else if (goal_team2 && !goal_team1) begin
          state_next     = ST_GOAL;
          score2_next    = score2_reg + 4'd1;
          serve_dir_next = 1'b1;
          timer_load     = 1'b1;
          timer_load_val = GOAL_VAL;
        end
      end

      ST_GOAL: begin
        if (timer_done) begin
          if (score1_reg == WIN_VAL) begin
            state_next  = ST_OVER;
            winner_next = WIN_TEAM1;
          end else if (score2_reg == WIN_VAL) begin
            state_next  = ST_OVER;
            winner_next = WIN_TEAM2;
          end else begin
            state_next     = ST_SERVE;
            timer_load     = 1'b1;
            timer_load_val = SERVE_VAL;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    play_en_next   = (state_next == ST_PLAY);
    pos_reset_next = (state_next == ST_SERVE) && (state_reg != ST_SERVE);
    first_next     = (state_next != state_reg) &&
                     ((state_next == ST_SERVE) || (state_next == ST_GOAL));
  end

  assign play_en     = play_en_reg;
  assign pos_reset   = pos_reset_reg;
  assign serve_dir   = serve_dir_reg;
  assign team1_score = score1_reg;
  assign team2_score = score2_reg;
  assign winner      = winner_reg;
  assign game_state  = state_reg;

endmodule

// File: tb/tb_match_controller.sv
// Directed testbench for match_controller with immediate assertions.
module tb_match_controller;

  localparam int WIN   = 7;
  localparam int SERVE = 60;
  localparam int GOALF = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_button = 1'b1;
  logic       goal_team1 = 1'b0;
  logic       goal_team2 = 1'b0;
  logic       play_en, pos_reset, serve_dir;
  logic [3:0] team1_score, team2_score;
  logic [1:0] winner;
  logic [2:0] game_state;

  int tests = 0;
  int failed = 0;

  match_controller #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SERVE),
    .GOAL_FRAMES  (GOALF),
    .TIMER_W      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .start_button (start_button),
    .goal_team1   (goal_team1),
    .goal_team2   (goal_team2),
    .play_en      (play_en),
    .pos_reset    (pos_reset),
    .serve_dir    (serve_dir),
    .team1_score  (team1_score),
    .team2_score  (team2_score),
    .winner       (winner),
    .game_state   (game_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame_tick pulse; returns just after the edge that sampled it.
  task automatic tick_pulse();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Starting in the SERVE entry cycle: run the serve and land in PLAY.
  task automatic serve_to_play(input string tag);
    step();
    for (int i = 0; i < SERVE - 1; i++) begin
      tick_pulse();
      step();
    end
    check({tag, "_serve_hold_state"}, 8'(game_state), 8'd1);
    check({tag, "_serve_hold_play_en"}, 8'(play_en), 8'd0);
    tick_pulse();
    check({tag, "_play_state"}, 8'(game_state), 8'd2);
    check({tag, "_play_en"}, 8'(play_en), 8'd1);
    step();
  endtask

  // From PLAY: score a goal and run out the celebration phase.
  task automatic goal_cycle(input string tag, input logic team2,
                            input logic [3:0] exp1, input logic [3:0] exp2);
    if (team2) goal_team2 = 1'b1;
    else       goal_team1 = 1'b1;
    step();
    goal_team1 = 1'b0;
    goal_team2 = 1'b0;
    check({tag, "_state"}, 8'(game_state), 8'd3);
    check({tag, "_score1"}, 8'(team1_score), 8'(exp1));
    check({tag, "_score2"}, 8'(team2_score), 8'(exp2));
    check({tag, "_dir"}, 8'(serve_dir), 8'(team2));
    check({tag, "_play_en"}, 8'(play_en), 8'd0);
    step();
    for (int i = 0; i < GOALF - 1; i++) begin
      tick_pulse();
      step();
    end
    check({tag, "_goal_hold"}, 8'(game_state), 8'd3);
    tick_pulse();
    $display("[TB] goal %s: scores %0d/%0d, state %0d", tag, team1_score, team2_score, game_state);
  endtask

  task automatic press_start();
    start_button = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_state", 8'(game_state), 8'd0);
    check("rst_play_en", 8'(play_en), 8'd0);
    check("rst_pos_reset", 8'(pos_reset), 8'd0);
    check("rst_winner", 8'(winner), 8'd0);
    step();
    rst_n = 1'b1;
    step();

    // No press: stays IDLE through 100 frames
    for (int i = 0; i < 100; i++) begin
      tick_pulse();
      step();
    end
    check("idle_hold", 8'(game_state), 8'd0);
    check("idle_pos_reset", 8'(pos_reset), 8'd0);
    $display("[TB] idle: 100 frames, state %0d", game_state);

    // Press: SERVE entered 3 clocks after the button falls
    press_start();
    check("start_state", 8'(game_state), 8'd1);
    check("start_pos_reset", 8'(pos_reset), 8'd1);
    check("start_dir", 8'(serve_dir), 8'd0);
    // A tick in the entry cycle must not be counted
    tick_pulse();
    check("start_pos_reset_one", 8'(pos_reset), 8'd0);
    start_button = 1'b1;
    for (int i = 0; i < SERVE - 1; i++) begin
      tick_pulse();
      step();
    end
    check("serve59_state", 8'(game_state), 8'd1);
    check("serve59_play_en", 8'(play_en), 8'd0);
    tick_pulse();
    check("serve60_state", 8'(game_state), 8'd2);
    check("serve60_play_en", 8'(play_en), 8'd1);
    step();
    $display("[TB] serve: play after %0d frames", SERVE);

    // Team2 goal, with goal pulses during GOAL ignored
    goal_team2 = 1'b1;
    step();
    goal_team2 = 1'b0;
    check("g2_state", 8'(game_state), 8'd3);
    check("g2_score2", 8'(team2_score), 8'd1);
    check("g2_dir", 8'(serve_dir), 8'd1);
    check("g2_play_en", 8'(play_en), 8'd0);
    step();
    goal_team1 = 1'b1;
    step();
    goal_team1 = 1'b0;
    goal_team2 = 1'b1;
    step();
    goal_team2 = 1'b0;
    check("ingoal_score1", 8'(team1_score), 8'd0);
    check("ingoal_score2", 8'(team2_score), 8'd1);
    for (int i = 0; i < GOALF - 1; i++) begin
      tick_pulse();
      step();
    end
    check("g2_goal_hold", 8'(game_state), 8'd3);
    tick_pulse();
    check("g2_reserve_state", 8'(game_state), 8'd1);
    check("g2_reserve_pos_reset", 8'(pos_reset), 8'd1);
    check("g2_reserve_dir", 8'(serve_dir), 8'd1);
    $display("[TB] goal team2: scores %0d/%0d", team1_score, team2_score);
    serve_to_play("g2");

    // Simultaneous goals are ignored
    goal_team1 = 1'b1;
    goal_team2 = 1'b1;
    step();
    goal_team1 = 1'b0;
    goal_team2 = 1'b0;
    check("both_state", 8'(game_state), 8'd2);
    check("both_score1", 8'(team1_score), 8'd0);
    check("both_score2", 8'(team2_score), 8'd1);
    $display("[TB] simultaneous goals: state %0d", game_state);

    // Button held in PLAY has no effect
    start_button = 1'b0;
    for (int i = 0; i < 1000; i++) step();
    check("hold_state", 8'(game_state), 8'd2);
    check("hold_play_en", 8'(play_en), 8'd1);
    start_button = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("release_state", 8'(game_state), 8'd2);
    $display("[TB] button held 1000 cycles in play: state %0d", game_state);

    // Build scores 3/2 and reset mid-PLAY
    goal_cycle("a1", 1'b0, 4'd1, 4'd1);
    serve_to_play("a1");
    goal_cycle("a2", 1'b0, 4'd2, 4'd1);
    serve_to_play("a2");
    goal_cycle("a3", 1'b1, 4'd2, 4'd2);
    serve_to_play("a3");
    goal_cycle("a4", 1'b0, 4'd3, 4'd2);
    serve_to_play("a4");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", 8'(game_state), 8'd0);
    check("midrst_score1", 8'(team1_score), 8'd0);
    check("midrst_score2", 8'(team2_score), 8'd0);
    check("midrst_play_en", 8'(play_en), 8'd0);
    check("midrst_dir", 8'(serve_dir), 8'd0);
    step();
    rst_n = 1'b1;
    step();
    $display("[TB] reset mid-play: state %0d scores %0d/%0d", game_state, team1_score, team2_score);

    // Full match to WIN_SCORE for team1
    press_start();
    start_button = 1'b1;
    check("m_start_state", 8'(game_state), 8'd1);
    serve_to_play("m0");
    for (int g = 1; g < WIN; g++) begin
      goal_cycle("m", 1'b0, 4'(g), 4'd0);
      check("m_reserve_state", 8'(game_state), 8'd1);
      check("m_reserve_pos_reset", 8'(pos_reset), 8'd1);
      serve_to_play("m");
    end
    goal_cycle("m7", 1'b0, 4'd7, 4'd0);
    check("over_state", 8'(game_state), 8'd4);
    check("over_winner", 8'(winner), 8'd1);
    check("over_play_en", 8'(play_en), 8'd0);
    check("over_pos_reset", 8'(pos_reset), 8'd0);
    for (int i = 0; i < 20; i++) begin
      tick_pulse();
      step();
    end
    check("over_hold_state", 8'(game_state), 8'd4);
    check("over_hold_winner", 8'(winner), 8'd1);
    $display("[TB] match over: winner %0d", winner);

    // Press from OVER restarts
    press_start();
    start_button = 1'b1;
    check("restart_state", 8'(game_state), 8'd1);
    check("restart_pos_reset", 8'(pos_reset), 8'd1);
    check("restart_score1", 8'(team1_score), 8'd0);
    check("restart_score2", 8'(team2_score), 8'd0);
    check("restart_winner", 8'(winner), 8'd0);
    check("restart_dir", 8'(serve_dir), 8'd0);
    $display("[TB] restart: state %0d", game_state);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
